dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache controller between the five-stage MEM stage and the word-addressed data RAM. It serves loads from a local line array and stalls the pipeline on misses and stores. It sequences the RAM's flag-driven load/store port with a programmable access latency, so slower memory can be modelled. The RAM is always read as a full word; the controller does all half/byte extraction.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_line_array.sv | 58 +++++
 rtl/dcache_ctrl.sv | 154 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared encodings, FSM state type and the load-result extension helper
// for the direct-mapped write-through data cache controller.
package dcache_pkg;

  localparam logic [1:0] LD_NONE = 2'b00;
  localparam logic [1:0] LD_W    = 2'b01;
  localparam logic [1:0] LD_H    = 2'b10;
  localparam logic [1:0] LD_B    = 2'b11;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_W    = 2'b01;
  localparam logic [1:0] ST_H    = 2'b10;
  localparam logic [1:0] ST_B    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_WAIT,
    S_DONE
  } state_e;

  // Bit 2 of the load flag selects sign extension for half/byte loads.
  function automatic logic [31:0] extend(input logic [31:0] word, input logic [2:0] ld_flag);
    logic [31:0] res;
    res = '0;
    case (ld_flag[1:0])
      LD_W:    res = word;
      LD_H:    res = ld_flag[2] ? {{16{word[15]}}, word[15:0]} : {16'h0000, word[15:0]};
      LD_B:    res = ld_flag[2] ? {{24{word[7]}}, word[7:0]} : {24'h000000, word[7:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// One-word-per-line storage: valid bits, tags and data with a combinational
// read port, a fill port, a byte/half/word merge port and a clear-all input.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [31:0]      o_rd_data,
  input  logic             i_fill_en,
  input  logic [IDX_W-1:0] i_fill_idx,
  input  logic [TAG_W-1:0] i_fill_tag,
  input  logic [31:0]      i_fill_data,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [1:0]       i_wr_flag,
  input  logic [31:0]      i_wr_data
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_valid <= '0;
    end else if (i_fill_en) begin
      r_valid[i_fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; a cleared valid bit already makes their contents unobservable.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_fill_idx]  <= i_fill_tag;
      r_data[i_fill_idx] <= i_fill_data;
    end else if (i_wr_en) begin
      case (i_wr_flag)
        ST_W:    r_data[i_wr_idx]       <= i_wr_data;
        ST_H:    r_data[i_wr_idx][15:0] <= i_wr_data[15:0];
        ST_B:    r_data[i_wr_idx][7:0]  <= i_wr_data[7:0];
        default: r_data[i_wr_idx]       <= r_data[i_wr_idx];
      endcase
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller that
// sequences a flag-driven word RAM port with a fixed access latency.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int IDX_W   = 4,
  parameter int MEM_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_load_flag,
  input  logic [1:0]  cpu_store_flag,
  input  logic        flush,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_write_flag,
  output logic [2:0]  mem_load_flag,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int         TAG_W = ADDR_W - IDX_W;
  localparam logic [3:0] LAT   = 4'(MEM_LAT);

  state_e           r_state, w_next_state;
  logic [3:0]       r_cnt, w_next_cnt;
  logic [31:0]      r_hit_cnt, r_miss_cnt;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag, w_line_tag;
  logic [31:0]      w_line_data;
  logic             w_line_valid, w_hit, w_is_store, w_is_load;
  logic             w_hit_inc, w_miss_inc, w_fill, w_merge, w_flush;
  logic             w_unused;

  assign w_idx      = cpu_addr[IDX_W-1:0];
  assign w_tag      = cpu_addr[ADDR_W-1:IDX_W];
  assign w_hit      = w_line_valid && (w_line_tag == w_tag);
  assign w_is_store = (cpu_store_flag != ST_NONE);
  assign w_is_load  = !w_is_store && (cpu_load_flag[1:0] != LD_NONE);
  assign w_unused   = ^cpu_addr[31:ADDR_W];

  assign mem_addr   = 32'(cpu_addr[ADDR_W-1:0]);
  assign mem_wdata  = cpu_wdata;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

  dcache_line_array #(
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_lines (
    .clk        (clk),
    .i_clear    (rst | w_flush),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data),
    .i_fill_en  (w_fill),
    .i_fill_idx (w_idx),
    .i_fill_tag (w_tag),
    .i_fill_data(mem_rdata),
    .i_wr_en    (w_merge),
    .i_wr_idx   (w_idx),
    .i_wr_flag  (cpu_store_flag),
    .i_wr_data  (cpu_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_hit_inc)  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_inc) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  // NOTE: combinational logic uses blocking assignments and gives every output a default first, so no latch is inferred.
  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    stall          = 1'b0;
    cpu_rdata      = '0;
    mem_load_flag  = 3'b000;
    mem_write_flag = ST_NONE;
    w_hit_inc      = 1'b0;
    w_miss_inc     = 1'b0;
    w_fill         = 1'b0;
    w_merge        = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_store) begin
          stall        = 1'b1;
          w_next_state = S_WR_WAIT;
          w_next_cnt   = LAT;
        end else if (w_is_load && w_hit) begin
          cpu_rdata = extend(w_line_data, cpu_load_flag);
          w_hit_inc = 1'b1;
        end else if (w_is_load) begin
          stall        = 1'b1;
          w_miss_inc   = 1'b1;
          w_next_state = S_RD_WAIT;
          w_next_cnt   = LAT;
        end else begin
          w_flush = flush;
        end
      end
      S_RD_WAIT: begin
        stall         = 1'b1;
        mem_load_flag = 3'b001;
        w_next_cnt    = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_fill       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        stall      = 1'b1;
        w_next_cnt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          mem_write_flag = cpu_store_flag;
          w_merge        = w_hit;
          w_next_state   = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // Reset aborts at once: nothing reaches the RAM or the line array this cycle.
    if (rst) begin
      stall          = 1'b0;
      cpu_rdata      = '0;
      mem_load_flag  = 3'b000;
      mem_write_flag = ST_NONE;
      w_fill         = 1'b0;
      w_merge        = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a driver pushes expected responses from an
// address-level cache/memory model, a monitor pops them when a request completes.
module tb_dcache_ctrl;

  localparam int ADDR_W = 7;
  localparam int IDX_W  = 4;
  localparam int LAT    = 3;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int LINES  = 2 ** IDX_W;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_load_flag;
  logic [1:0]  cpu_store_flag;
  logic        flush, stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, hit_cnt, miss_cnt;
  logic [1:0]  mem_write_flag;
  logic [2:0]  mem_load_flag;

  dcache_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .MEM_LAT(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_load_flag (cpu_load_flag),
    .cpu_store_flag(cpu_store_flag),
    .flush         (flush),
    .cpu_rdata     (cpu_rdata),
    .stall         (stall),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_write_flag(mem_write_flag),
    .mem_load_flag (mem_load_flag),
    .mem_rdata     (mem_rdata),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] init_word(input int a);
    if (a == 5) return 32'h1234_5678;
    if (a == 6) return 32'hFFFF_8001;
    if (a == 2) return 32'h5566_7788;
    return 32'(a) * 32'h9E37_79B9 + 32'h0F1E_2D3C;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [1:0] st);
    if (st == 2'b01) return wd;
    if (st == 2'b10) return (old & 32'hFFFF_0000) | (wd & 32'h0000_FFFF);
    if (st == 2'b11) return (old & 32'hFFFF_FF00) | (wd & 32'h0000_00FF);
    return old;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] f);
    int unsigned v;
    case (f[1:0])
      2'b01: return w;
      2'b10: begin
        v = w % 65536;
        return (f[2] && v >= 32768) ? v + 32'hFFFF_0000 : v;
      end
      2'b11: begin
        v = w % 256;
        return (f[2] && v >= 128) ? v + 32'hFFFF_FF00 : v;
      end
      default: return 32'h0;
    endcase
  endfunction

  // Word RAM: combinational read only while the load flag is asserted.
  logic [31:0] ram [DEPTH];
  int ram_writes = 0;
  assign mem_rdata = (mem_load_flag == 3'b001) ? ram[mem_addr[ADDR_W-1:0]] : 32'hDEAD_BEEF;

  initial begin
    for (int a = 0; a < DEPTH; a++) ram[a] = init_word(a);
    forever begin
      @(posedge clk);
      if (mem_write_flag != 2'b00) begin
        ram[mem_addr[ADDR_W-1:0]] = merge(ram[mem_addr[ADDR_W-1:0]], mem_wdata, mem_write_flag);
        ram_writes++;
      end
    end
  end

  // Reference model: memory contents and which word addresses are currently cached.
  logic [31:0] golden [DEPTH];
  bit          cached [DEPTH];
  int          exp_hits = 0;
  int          exp_miss = 0;

  typedef struct {
    bit          is_store;
    logic [1:0]  st;
    logic [31:0] rdata;
    int          stall;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: counts stall cycles and write pulses of the current request, checks on completion.
  initial begin
    int          stall_cnt;
    int          wr_n;
    int          wr_at;
    logic [1:0]  wr_flag;
    exp_t        e;
    stall_cnt = 0;
    wr_n      = 0;
    wr_at     = 0;
    wr_flag   = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
        wr_n      = 0;
      end else if (cpu_load_flag[1:0] != 2'b00 || cpu_store_flag != 2'b00) begin
        if (mem_write_flag != 2'b00) begin
          wr_n++;
          wr_at   = stall_cnt;
          wr_flag = mem_write_flag;
        end
        if (stall) begin
          stall_cnt++;
        end else begin
          check("completion_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rdata", cpu_rdata, e.rdata);
            check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            check("write_pulses", 32'(wr_n), e.is_store ? 32'd1 : 32'd0);
            if (e.is_store) begin
              check("write_cycle", 32'(wr_at), 32'(LAT));
              check("write_flag", 32'(wr_flag), 32'(e.st));
            end
          end
          stall_cnt = 0;
          wr_n      = 0;
        end
      end
    end
  end

  task automatic check_counters(input string tag);
    check({tag, "_hit_cnt"}, hit_cnt, 32'(exp_hits));
    check({tag, "_miss_cnt"}, miss_cnt, 32'(exp_miss));
  endtask

  // Issue one request at posedge+1; returns at posedge+1 after it completes.
  task automatic issue(input int a, input logic [2:0] ld, input logic [1:0] st,
                       input logic [31:0] wd, input logic fl);
    exp_t e;
    bit   done;
    e.is_store = (st != 2'b00);
    e.st       = st;
    e.rdata    = 32'h0;
    e.stall    = LAT + 1;
    if (e.is_store) begin
      golden[a] = merge(golden[a], wd, st);
    end else begin
      e.rdata = ref_ext(golden[a], ld);
      exp_hits++;
      if (cached[a]) begin
        e.stall = 0;
      end else begin
        exp_miss++;
        for (int j = 0; j < DEPTH; j++) if (j % LINES == a % LINES) cached[j] = 0;
        cached[a] = 1;
      end
    end
    exp_q.push_back(e);
    cpu_addr       = ($urandom() << ADDR_W) | 32'(a);
    cpu_load_flag  = ld;
    cpu_store_flag = st;
    cpu_wdata      = wd;
    flush          = fl;
    done = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        break;
      end
    end
    if (!done) check("completion_timeout", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    cpu_load_flag  = 3'b000;
    cpu_store_flag = 2'b00;
    flush          = 1'b0;
  endtask

  task automatic idle(input int n, input logic fl);
    flush = fl;
    if (fl) for (int j = 0; j < DEPTH; j++) cached[j] = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < DEPTH; j++) cached[j] = 0;
    exp_hits = 0;
    exp_miss = 0;
  endtask

  initial begin
    int          w0;
    int          bad;
    int          a;
    int          r;
    logic [2:0]  ld;
    logic [1:0]  st;
    for (int j = 0; j < DEPTH; j++) begin
      golden[j] = init_word(j);
      cached[j] = 0;
    end
    rst            = 1'b1;
    cpu_addr       = '0;
    cpu_wdata      = '0;
    cpu_load_flag  = 3'b000;
    cpu_store_flag = 2'b00;
    flush          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_rdata", cpu_rdata, 32'h0);
    check("reset_wflag", 32'(mem_write_flag), 32'd0);
    check("reset_lflag", 32'(mem_load_flag), 32'd0);
    check_counters("reset");
    @(posedge clk);
    #1;

    issue(5, 3'b001, 2'b00, 32'h0, 1'b0);
    check_counters("first_miss");
    issue(5, 3'b001, 2'b00, 32'h0, 1'b0);
    check_counters("first_hit");

    issue(5, 3'b000, 2'b01, 32'h0000_00F0, 1'b0);
    issue(5, 3'b111, 2'b00, 32'h0, 1'b0);
    issue(6, 3'b010, 2'b00, 32'h0, 1'b0);

    issue(2, 3'b001, 2'b00, 32'h0, 1'b0);
    issue(2, 3'b000, 2'b11, 32'h1234_56AB, 1'b0);
    issue(2, 3'b001, 2'b00, 32'h0, 1'b0);

    w0 = ram_writes;
    issue(20, 3'b000, 2'b01, 32'hCAFE_F00D, 1'b0);
    check("store_miss_ram_writes", 32'(ram_writes - w0), 32'd1);
    issue(20, 3'b001, 2'b00, 32'h0, 1'b0);

    for (int k = 0; k < 4; k++) issue((k % 2 == 0) ? 3 : 19, 3'b001, 2'b00, 32'h0, 1'b0);

    issue(5, 3'b001, 2'b00, 32'h0, 1'b0);
    idle(1, 1'b1);
    issue(5, 3'b001, 2'b00, 32'h0, 1'b0);
    issue(5, 3'b001, 2'b00, 32'h0, 1'b1);
    issue(5, 3'b001, 2'b00, 32'h0, 1'b0);
    issue(5, 3'b001, 2'b10, 32'h0000_4321, 1'b0);
    issue(5, 3'b001, 2'b00, 32'h0, 1'b0);
    check_counters("directed");

    // Reset in the second RD_WAIT cycle of a load miss.
    w0 = ram_writes;
    cpu_addr      = 32'd7;
    cpu_load_flag = 3'b001;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    cpu_load_flag = 3'b000;
    model_reset();
    check("rd_abort_stall", 32'(stall), 32'd0);
    check("rd_abort_ram_writes", 32'(ram_writes - w0), 32'd0);
    check_counters("rd_abort");
    issue(5, 3'b001, 2'b00, 32'h0, 1'b0);
    check_counters("after_rd_abort");

    // Reset in the write cycle of a store: the RAM must not be written.
    w0 = ram_writes;
    cpu_addr       = 32'd9;
    cpu_store_flag = 2'b01;
    cpu_wdata      = 32'hBAD0_BAD0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("wr_abort_wflag", 32'(mem_write_flag), 32'd0);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    cpu_store_flag = 2'b00;
    model_reset();
    check("wr_abort_ram_writes", 32'(ram_writes - w0), 32'd0);
    check("wr_abort_stall", 32'(stall), 32'd0);

    for (int t = 0; t < 400; t++) begin
      a  = $urandom_range(0, 47);
      r  = $urandom_range(0, 9);
      ld = {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
      st = 2'($urandom_range(1, 3));
      if (r < 6) st = 2'b00;
      else if (r < 9) ld = 3'b000;
      issue(a, ld, st, $urandom(), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), ($urandom_range(0, 5) == 0));
    end

    idle(3, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check_counters("final");
    bad = 0;
    for (int j = 0; j < DEPTH; j++) if (ram[j] !== golden[j]) bad++;
    check("ram_image_mismatches", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
